// File: rtl/req_ack_window_monitor.sv
// -----------------------------------------------------------------------------
// req_ack_window_monitor
//
// Multi-channel request/acknowledge timing monitor. On every channel, each
// sampled request must be answered by an acknowledge between MIN_DLY and
// MAX_DLY rising edges after the edge that sampled it. Overlapping requests
// are tracked at the same time in a per-channel age vector. One ack retires
// every outstanding request that is currently inside the window.
//
// Ports:
//   clk         sole clock; all sampling on the rising edge
//   rst_n       asynchronous active-low reset; clears all state
//   en          1: accept new requests; 0: ignore new ones, in-flight resolve
//   clr         synchronous clear of counters and sticky flags (not ages)
//   req[N_CH]   per-channel request
//   ack[N_CH]   per-channel acknowledge
//   pass_pulse  1-cycle pulse: an ack satisfied >=1 pending request
//   fail_pulse  1-cycle pulse: a request expired without an ack
//   pass_cnt    saturating satisfied-request counts, channel i at [i*CNT_W +: CNT_W]
//   fail_cnt    saturating expired-request counts, same packing
//   err_sticky  set by the first failure on a channel, held until clr/reset
// -----------------------------------------------------------------------------
module req_ack_window_monitor #(
  parameter int N_CH    = 2,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH-1:0]       ack,
  output logic [N_CH-1:0]       pass_pulse,
  output logic [N_CH-1:0]       fail_pulse,
  output logic [N_CH*CNT_W-1:0] pass_cnt,
  output logic [N_CH*CNT_W-1:0] fail_cnt,
  output logic [N_CH-1:0]       err_sticky
);

  // Reject configurations the age vector cannot represent.
  if (N_CH < 1 || MIN_DLY < 1 || MAX_DLY < MIN_DLY || MAX_DLY > 32) begin : g_param_err
    $error("req_ack_window_monitor: illegal parameters N_CH=%0d MIN_DLY=%0d MAX_DLY=%0d",
           N_CH, MIN_DLY, MAX_DLY);
  end

  // Width needed to count up to MAX_DLY requests retired by a single ack.
  localparam int PC_W  = $clog2(MAX_DLY + 1);
  // Wide enough that count + retirements can never wrap before saturation.
  localparam int SUM_W = CNT_W + PC_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Ages MIN_DLY..MAX_DLY are the ones an ack is allowed to retire.
  function automatic logic [MAX_DLY:1] make_win_mask();
    logic [MAX_DLY:1] m;
    for (int k = 1; k <= MAX_DLY; k++) begin
      m[k] = (k >= MIN_DLY);
    end
    return m;
  endfunction

  localparam logic [MAX_DLY:1] WIN_MASK = make_win_mask();

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    // age_q[k] = 1: a request sampled k edges ago is still outstanding.
    logic [MAX_DLY:1] age_q, age_d;
    logic [MAX_DLY:1] retired;
    logic [PC_W-1:0]  n_retired;
    logic             hit, expire;
    logic [SUM_W-1:0] pass_sum;
    logic [CNT_W-1:0] pass_cnt_d, fail_cnt_d;

    logic             pass_q, fail_q, err_q;
    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;

    // NOTE: every variable written here gets a value before any conditional
    // logic, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
      retired    = '0;
      n_retired  = '0;
      age_d      = '0;
      if (ack[ch]) begin
        retired = age_q & WIN_MASK;
      end
      hit = |retired;
      // An ack on the last age retires it as a pass, so it cannot also expire.
      expire = age_q[MAX_DLY] & ~ack[ch];

      for (int k = 1; k <= MAX_DLY; k++) begin
        n_retired = n_retired + PC_W'(retired[k]);
      end

      // The request sampled on this edge enters at age 1, so an ack on the
      // same edge can never retire it. The oldest age drops off the end.
      age_d[1] = req[ch] & en;
      for (int k = 2; k <= MAX_DLY; k++) begin
        age_d[k] = age_q[k-1] & ~retired[k-1];
      end

      pass_sum   = SUM_W'(pass_cnt_q) + SUM_W'(n_retired);
      pass_cnt_d = (pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_W-1:0];
      fail_cnt_d = (fail_cnt_q == CNT_MAX) ? CNT_MAX : fail_cnt_q + CNT_W'(expire);
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order. The age
    // vector is reset too: outstanding requests are dropped on reset, never
    // reported as failures afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        age_q      <= '0;
        pass_q     <= 1'b0;
        fail_q     <= 1'b0;
        err_q      <= 1'b0;
        pass_cnt_q <= '0;
        fail_cnt_q <= '0;
      end else begin
        age_q  <= age_d;
        pass_q <= hit;
        fail_q <= expire;
        // clr beats a simultaneous event; pulses and ages are unaffected.
        if (clr) begin
          err_q      <= 1'b0;
          pass_cnt_q <= '0;
          fail_cnt_q <= '0;
        end else begin
          err_q      <= err_q | expire;
          pass_cnt_q <= pass_cnt_d;
          fail_cnt_q <= fail_cnt_d;
        end
      end
    end

    assign pass_pulse[ch]                  = pass_q;
    assign fail_pulse[ch]                  = fail_q;
    assign err_sticky[ch]                  = err_q;
    assign pass_cnt[ch*CNT_W +: CNT_W]     = pass_cnt_q;
    assign fail_cnt[ch*CNT_W +: CNT_W]     = fail_cnt_q;
  end

endmodule

// File: tb/tb_req_ack_window_monitor.sv
// -----------------------------------------------------------------------------
// tb_req_ack_window_monitor
//
// Drives two monitor instances with the same inputs:
//   dut_a : defaults (MIN_DLY=1, MAX_DLY=3, CNT_W=8)
//   dut_b : MIN_DLY=2, MAX_DLY=4, CNT_W=2 (early ack and saturation cases)
// A reference model keeps, per instance and channel, a queue of the edge
// numbers at which requests were sampled and derives every output from the
// request ages. Directed scenarios run first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_req_ack_window_monitor;

  localparam int N_CH = 2;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            clr;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] ack;

  logic [N_CH-1:0]   a_pp, a_fp, a_es;
  logic [N_CH*8-1:0] a_pc, a_fc;
  logic [N_CH-1:0]   b_pp, b_fp, b_es;
  logic [N_CH*2-1:0] b_pc, b_fc;

  req_ack_window_monitor #(.N_CH(N_CH), .MIN_DLY(1), .MAX_DLY(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req), .ack(ack),
    .pass_pulse(a_pp), .fail_pulse(a_fp), .pass_cnt(a_pc), .fail_cnt(a_fc),
    .err_sticky(a_es)
  );

  req_ack_window_monitor #(.N_CH(N_CH), .MIN_DLY(2), .MAX_DLY(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req), .ack(ack),
    .pass_pulse(b_pp), .fail_pulse(b_fp), .pass_cnt(b_pc), .fail_cnt(b_fc),
    .err_sticky(b_es)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: index 0 = dut_a, 1 = dut_b
  // ---------------------------------------------------------------------------
  int edge_n = 0;
  int q    [2][N_CH][$];
  bit m_pp [2][N_CH];
  bit m_fp [2][N_CH];
  bit m_es [2][N_CH];
  int m_pc [2][N_CH];
  int m_fc [2][N_CH];

  function automatic int min_dly(input int d); return (d == 0) ? 1 : 2; endfunction
  function automatic int max_dly(input int d); return (d == 0) ? 3 : 4; endfunction
  function automatic int cnt_max(input int d); return (d == 0) ? 255 : 3; endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N_CH; c++) begin
        q[d][c].delete();
        m_pp[d][c] = 0; m_fp[d][c] = 0; m_es[d][c] = 0;
        m_pc[d][c] = 0; m_fc[d][c] = 0;
      end
    end
  endtask

  // Applies one rising edge to the model using the inputs sampled on it.
  task automatic model_edge(input int d);
    for (int c = 0; c < N_CH; c++) begin
      int keep[$];
      int n_ok = 0;
      bit ex   = 0;
      foreach (q[d][c][i]) begin
        int age;
        age = edge_n - q[d][c][i];
        if (ack[c] && age >= min_dly(d) && age <= max_dly(d)) n_ok++;
        else if (age >= max_dly(d)) ex = 1;
        else keep.push_back(q[d][c][i]);
      end
      q[d][c] = keep;
      if (req[c] && en) q[d][c].push_back(edge_n);

      m_pp[d][c] = (n_ok > 0);
      m_fp[d][c] = ex;
      if (clr) begin
        m_pc[d][c] = 0;
        m_fc[d][c] = 0;
        m_es[d][c] = 0;
      end else begin
        m_pc[d][c] = (m_pc[d][c] + n_ok > cnt_max(d)) ? cnt_max(d) : m_pc[d][c] + n_ok;
        m_fc[d][c] = (m_fc[d][c] + int'(ex) > cnt_max(d)) ? cnt_max(d) : m_fc[d][c] + int'(ex);
        m_es[d][c] = m_es[d][c] | ex;
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("a.pass_pulse[%0d]", c), 32'(a_pp[c]), 32'(m_pp[0][c]));
      check($sformatf("a.fail_pulse[%0d]", c), 32'(a_fp[c]), 32'(m_fp[0][c]));
      check($sformatf("a.err_sticky[%0d]", c), 32'(a_es[c]), 32'(m_es[0][c]));
      check($sformatf("a.pass_cnt[%0d]", c),   32'(a_pc[c*8 +: 8]), 32'(m_pc[0][c]));
      check($sformatf("a.fail_cnt[%0d]", c),   32'(a_fc[c*8 +: 8]), 32'(m_fc[0][c]));
      check($sformatf("b.pass_pulse[%0d]", c), 32'(b_pp[c]), 32'(m_pp[1][c]));
      check($sformatf("b.fail_pulse[%0d]", c), 32'(b_fp[c]), 32'(m_fp[1][c]));
      check($sformatf("b.err_sticky[%0d]", c), 32'(b_es[c]), 32'(m_es[1][c]));
      check($sformatf("b.pass_cnt[%0d]", c),   32'(b_pc[c*2 +: 2]), 32'(m_pc[1][c]));
      check($sformatf("b.fail_cnt[%0d]", c),   32'(b_fc[c*2 +: 2]), 32'(m_fc[1][c]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a.pulses"},   32'({a_pp, a_fp}), 32'd0);
    check({tag, " a.counts"},   32'({a_pc, a_fc}), 32'd0);
    check({tag, " a.sticky"},   32'(a_es), 32'd0);
    check({tag, " b.pulses"},   32'({b_pp, b_fp}), 32'd0);
    check({tag, " b.counts"},   32'({b_pc, b_fc}), 32'd0);
    check({tag, " b.sticky"},   32'(b_es), 32'd0);
  endtask

  // One rising edge: DUTs and model see the same inputs, outputs are
  // compared 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  task automatic cyc(input logic [N_CH-1:0] r, input logic [N_CH-1:0] a);
    req = r;
    ack = a;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0);
  endtask

  // Asynchronous reset between edges; outputs must clear without an edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    req   = '0;
    ack   = '0;
    model_clear();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single req answered at age 3.
    cyc(2'b01, 2'b00);
    idle(2);
    cyc(2'b00, 2'b01);
    check("plan1 a.pass_pulse0", 32'(a_pp[0]), 32'd1);
    check("plan1 a.pass_cnt0", 32'(a_pc[7:0]), 32'd1);
    check("plan1 a.fail_cnt0", 32'(a_fc[7:0]), 32'd0);
    idle(4);

    // Single req, never answered.
    cyc(2'b01, 2'b00);
    idle(3);
    check("plan2 a.fail_pulse0", 32'(a_fp[0]), 32'd1);
    check("plan2 a.fail_cnt0", 32'(a_fc[7:0]), 32'd1);
    idle(3);
    check("plan2 a.err_sticky0 held", 32'(a_es[0]), 32'd1);

    // Overlap: two reqs retired by one ack.
    clr = 1'b1; cyc('0, '0); clr = 1'b0;
    idle(2);
    cyc(2'b01, 2'b00);
    cyc(2'b01, 2'b00);
    cyc(2'b00, 2'b01);
    check("plan3 a.pass_cnt0", 32'(a_pc[7:0]), 32'd2);
    idle(5);

    // Overlap expiry: reqs at three edges, ack on the second.
    clr = 1'b1; cyc('0, '0); clr = 1'b0;
    cyc(2'b01, 2'b00);
    cyc(2'b01, 2'b01);
    cyc(2'b01, 2'b00);
    idle(3);
    check("plan4 a.pass_cnt0", 32'(a_pc[7:0]), 32'd1);
    check("plan4 a.fail_cnt0", 32'(a_fc[7:0]), 32'd2);
    idle(3);

    // Early ack for dut_b (age 1 < MIN_DLY), later fail at age 4.
    clr = 1'b1; cyc('0, '0); clr = 1'b0;
    cyc(2'b01, 2'b00);
    cyc(2'b00, 2'b01);
    check("plan5 b.pass_pulse0", 32'(b_pp[0]), 32'd0);
    idle(3);
    check("plan5 b.fail_pulse0", 32'(b_fp[0]), 32'd1);
    idle(3);

    // Saturation on the 2-bit counters of dut_b.
    clr = 1'b1; cyc('0, '0); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(2'b01, 2'b00);
      cyc(2'b00, 2'b00);
      cyc(2'b00, 2'b01);
    end
    check("sat b.pass_cnt0", 32'(b_pc[1:0]), 32'd3);
    clr = 1'b1; cyc('0, '0); clr = 1'b0;
    check("clr b.pass_cnt0", 32'(b_pc[1:0]), 32'd0);

    // Same-edge req and ack: the new req is not retired by that ack.
    cyc(2'b01, 2'b01);
    idle(5);

    // Pending reqs then reset: discarded, no later fail.
    cyc(2'b11, 2'b00);
    cyc(2'b01, 2'b00);
    mid_reset("mid reset");
    idle(6);
    check("post reset a.fail_cnt0", 32'(a_fc[7:0]), 32'd0);

    // Channel 1 traffic only; channel 0 must stay quiet.
    for (int i = 0; i < 6; i++) cyc(2'b10, (i % 2 == 1) ? 2'b10 : 2'b00);
    idle(5);
    check("ch1 only a.pass_cnt0", 32'(a_pc[7:0]), 32'd0);

    // en dropped with reqs in flight and req still high.
    cyc(2'b11, 2'b00);
    en = 1'b0;
    cyc(2'b11, 2'b00);
    cyc(2'b11, 2'b10);
    idle(5);
    en = 1'b1;

    // Randomized traffic with occasional clr, en drops and resets.
    for (int i = 0; i < 2500; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 59) == 0);
      cyc(N_CH'($urandom_range(0, 3)), N_CH'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0));
      if ($urandom_range(0, 399) == 0) mid_reset("rand reset");
    end
    clr = 1'b0;
    en  = 1'b1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/req_ack_window_monitor.md
Name: req_ack_window_monitor

Overview:
- Synthesizable, multi-channel request/acknowledge timing monitor.
- Checks "req |-> ##[MIN_DLY:MAX_DLY] ack" independently per channel; overlapping requests are tracked concurrently.
- Reports per-request pass/fail pulses, saturating counters and a sticky error flag.
- Sits beside any req/ack interface in simulation or on silicon as a protocol watchdog feeding status registers.

Parameters:
N_CH, 2, number of independent req/ack channels (>=1)
MIN_DLY, 1, earliest acceptable ack, in cycles after req sample (>=1)
MAX_DLY, 3, latest acceptable ack, in cycles after req sample (>=MIN_DLY, <=32)
CNT_W, 8, width of each pass/fail counter

Ports:
clk  input  1  sole clock; all sampling on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  1: new req samples are accepted; 0: new reqs ignored, in-flight reqs still resolve
clr  input  1  synchronous clear of counters and sticky flag; does not flush in-flight reqs
req  input  N_CH  per-channel request
ack  input  N_CH  per-channel acknowledge
pass_pulse  output  N_CH  1-cycle pulse: an ack satisfied >=1 pending req on that channel
fail_pulse  output  N_CH  1-cycle pulse: >=1 req on that channel expired without ack
pass_cnt  output  N_CH*CNT_W  per-channel satisfied-req count; channel i at [i*CNT_W +: CNT_W]
fail_cnt  output  N_CH*CNT_W  per-channel expired-req count, same packing
err_sticky  output  N_CH  set on first failure per channel, held until clr or reset

Behaviour:
- Per-channel age vector p[1..MAX_DLY]. p[k]=1 means a req sampled k edges ago is outstanding.
- At each rising edge e, with req/ack sampled at e:
  - win = OR of p[MIN_DLY..MAX_DLY].
  - hit = ack & win.
  - expire = p[MAX_DLY] & ~ack.
  - Shift: p[1] <= req & en. For k>=1, p[k+1] <= p[k] & ~(ack & MIN_DLY<=k<=MAX_DLY). p[MAX_DLY] drops off the end.
- One ack satisfies all outstanding reqs inside the window at once, as in concurrent assertion threads.
  - pass_cnt increments by popcount of cleared window bits, saturating at 2^CNT_W-1.
- Early ack (all pending ages < MIN_DLY): no effect; those reqs stay pending.
- Ack with nothing pending: ignored, no pulse, no count.
- req held high for L cycles creates L independent reqs.
- Same-edge new req and ack: the ack never satisfies the req sampled on that edge (minimum age 1).
- Outputs are registered; latency is 1 cycle after the deciding edge.
  - pass_pulse = hit.
  - fail_pulse = expire.
  - fail_cnt += expire (at most 1 per edge), saturating.
  - err_sticky |= expire.
- clr with a simultaneous event: clr wins; counters read 0 and err_sticky reads 0 on the next cycle.
  - Pulses still fire.
  - p is untouched.
- en low mid-operation: pending reqs still pass or fail normally.
- Reset (async assert, any time):
  - p, pass_pulse, fail_pulse, pass_cnt, fail_cnt and err_sticky all go to 0 immediately.
  - Outstanding reqs are discarded with no fail report.
  - Deassertion is synchronised by the integrating design.
- Channels are fully independent; no cross-channel interaction.
- Elaboration error if MIN_DLY<1, MAX_DLY<MIN_DLY, MAX_DLY>32, or N_CH<1.

Test Plan:
- Defaults, ch0: req=1 at edge 1 only, ack=1 at edge 4 -> pass_pulse[0]=1 after edge 4; pass_cnt[0]=1; fail_cnt[0]=0.
- Defaults, ch0: req at edge 1, no ack -> fail_pulse[0]=1 after edge 4; fail_cnt[0]=1; err_sticky[0]=1 and holds.
- Overlap, ch0: req high edges 1-2, ack at edge 3 -> single pass_pulse; pass_cnt[0]=2.
- Overlap expiry, ch0: req high edges 1-3, ack at edge 2 -> pass_cnt[0]=1, then fail_pulse after edges 5 and 6; fail_cnt[0]=2.
- Early ack, MIN_DLY=2, MAX_DLY=4: req at edge 1, ack at edge 2 only -> no pass; fail after edge 5.
- Saturation and control, CNT_W=2:
  - 5 passes -> pass_cnt=3.
  - clr pulse -> 0.
  - rst_n low with req pending -> all outputs 0 immediately, no later fail.
  - Ch1 traffic leaves ch0 counters unchanged.
